// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath widths, the bubble instruction and the
// fetch-stage state encoding, used by the IF, ID and hazard logic.
package pipe_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  // Next-PC source selected by the fetch controller.
  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_LOAD = 2'd2
  } pc_sel_e;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input logic [ADDR_W-1:0] depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/if_pc_reg.sv
// Program counter register with its incrementer and the target/hold/pc+1
// next-PC mux.
module if_pc_reg
  import pipe_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  pc_sel_e           sel_i,
  input  logic [ADDR_W-1:0] target_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus1_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  assign pc_o       = pc_q;
  assign pc_plus1_o = pc_q + ADDR_W'(1);

  always_comb begin
    pc_d = pc_q;
    case (sel_i)
      PC_INC:  pc_d = pc_plus1_o;
      PC_LOAD: pc_d = target_i;
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: drives the PC into a combinational instruction
// memory and captures the returned word into the IF/ID latch.
module if_fetch_unit
  import pipe_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  RESET_PC  = 32'd0,
  parameter int unsigned        MEM_DEPTH = 128,
  parameter logic [INSTR_W-1:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_npc,
  output logic               ifid_valid,
  output logic               halted
);

  localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(MEM_DEPTH);

  fetch_state_e       state_q, state_d;
  pc_sel_e            pc_sel;
  logic [ADDR_W-1:0]  pc_cur, pc_plus1;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [ADDR_W-1:0]  ifid_npc_q, ifid_npc_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic               halted_q;
  logic               target_ok;
  logic               last_word;

  if_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst        (rst),
    .sel_i      (pc_sel),
    .target_i   (branch_target),
    .pc_o       (pc_cur),
    .pc_plus1_o (pc_plus1)
  );

  assign target_ok = addr_in_range(branch_target, DEPTH);
  assign last_word = (pc_plus1 == DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (flush && !target_ok) state_d = HALT;
        else                     state_d = FETCH;
      end
      FETCH: begin
        if (flush)       state_d = target_ok ? FETCH : HALT;
        else if (stall)  state_d = FETCH;
        else if (last_word) state_d = HALT;
      end
      HALT: begin
        if (flush && target_ok) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_sel       = PC_HOLD;
    ifid_instr_d = ifid_instr_q;
    ifid_npc_d   = ifid_npc_q;
    ifid_valid_d = ifid_valid_q;
    case (state_q)
      IDLE: begin
        if (flush) pc_sel = PC_LOAD;
      end
      FETCH: begin
        if (flush) begin
          pc_sel       = PC_LOAD;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
        end else if (!stall) begin
          ifid_instr_d = imem_data;
          ifid_npc_d   = pc_plus1;
          ifid_valid_d = 1'b1;
          // Park the PC on the last word so imem_addr never leaves the array.
          pc_sel       = last_word ? PC_HOLD : PC_INC;
        end
      end
      HALT: begin
        if (flush && target_ok) begin
          pc_sel       = PC_LOAD;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
        end else if (!stall) begin
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
        end
      end
      default: pc_sel = PC_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_instr_q <= NOP_INSTR;
      ifid_npc_q   <= '0;
      ifid_valid_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      ifid_instr_q <= ifid_instr_d;
      ifid_npc_q   <= ifid_npc_d;
      ifid_valid_q <= ifid_valid_d;
      halted_q     <= (state_d == HALT);
    end
  end

  assign imem_addr  = pc_cur;
  assign pc         = pc_cur;
  assign ifid_instr = ifid_instr_q;
  assign ifid_npc   = ifid_npc_q;
  assign ifid_valid = ifid_valid_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit against a 128-word combinational memory model.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        flush;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_npc;
  logic        ifid_valid;
  logic        halted;

  logic [31:0] mem [128];

  int checks   = 0;
  int failures = 0;

  if_fetch_unit #(
    .RESET_PC  (32'd0),
    .MEM_DEPTH (128),
    .NOP_INSTR (32'h0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .stall         (stall),
    .flush         (flush),
    .branch_target (branch_target),
    .pc            (pc),
    .ifid_instr    (ifid_instr),
    .ifid_npc      (ifid_npc),
    .ifid_valid    (ifid_valid),
    .halted        (halted)
  );

  assign imem_data = (imem_addr < 32'd128) ? mem[imem_addr[6:0]] : 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                           input logic [31:0] e_npc, input logic e_valid, input logic e_halted);
    check({tag, ".pc"}, pc, e_pc);
    check({tag, ".imem_addr"}, imem_addr, e_pc);
    check({tag, ".instr"}, ifid_instr, e_instr);
    check({tag, ".npc"}, ifid_npc, e_npc);
    check({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, e_valid});
    check({tag, ".halted"}, {31'd0, halted}, {31'd0, e_halted});
    $display("step %-10s pc=%0d instr=%h npc=%0d valid=%0b halted=%0b",
             tag, pc, ifid_instr, ifid_npc, ifid_valid, halted);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'hC000_0000 | i;
    mem[0] = 32'h0023_00AA;
    mem[1] = 32'h1065_4321;
    mem[2] = 32'h0010_0022;

    rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_target = 32'd0;
    step();
    step();
    check_all("reset", 32'd0, 32'h0, 32'd0, 1'b0, 1'b0);

    // Free run from reset: one IDLE cycle, then words 0..2.
    rst = 1'b0;
    step(); check_all("idle", 32'd0, 32'h0, 32'd0, 1'b0, 1'b0);
    step(); check_all("w0", 32'd1, 32'h0023_00AA, 32'd1, 1'b1, 1'b0);
    step(); check_all("w1", 32'd2, 32'h1065_4321, 32'd2, 1'b1, 1'b0);

    // Three stall cycles hold PC and IF/ID.
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(); check_all("stall", 32'd2, 32'h1065_4321, 32'd2, 1'b1, 1'b0);
    end
    stall = 1'b0;
    step(); check_all("w2", 32'd3, 32'h0010_0022, 32'd3, 1'b1, 1'b0);

    // Flush beats stall.
    stall = 1'b1; flush = 1'b1; branch_target = 32'd8;
    step(); check_all("flush8", 32'd8, 32'h0, 32'd3, 1'b0, 1'b0);
    stall = 1'b0; flush = 1'b0;
    step(); check_all("w8", 32'd9, 32'hC000_0008, 32'd9, 1'b1, 1'b0);

    // Run off the end of memory.
    flush = 1'b1; branch_target = 32'd126;
    step(); check_all("flush126", 32'd126, 32'h0, 32'd9, 1'b0, 1'b0);
    flush = 1'b0;
    step(); check_all("w126", 32'd127, 32'hC000_007E, 32'd127, 1'b1, 1'b0);
    step(); check_all("w127", 32'd127, 32'hC000_007F, 32'd128, 1'b1, 1'b1);
    step(); check_all("drain", 32'd127, 32'h0, 32'd128, 1'b0, 1'b1);

    // Leave HALT with an in-range flush.
    flush = 1'b1; branch_target = 32'd3;
    step(); check_all("unhalt", 32'd3, 32'h0, 32'd128, 1'b0, 1'b0);
    flush = 1'b0;
    step(); check_all("w3", 32'd4, 32'hC000_0003, 32'd4, 1'b1, 1'b0);

    // Out-of-range target halts at once with nothing captured.
    flush = 1'b1; branch_target = 32'd200;
    step(); check_all("flush200", 32'd200, 32'h0, 32'd4, 1'b0, 1'b1);
    flush = 1'b0;
    step(); check_all("halt_hold", 32'd200, 32'h0, 32'd4, 1'b0, 1'b1);

    // Reset in the middle of a run dominates flush.
    flush = 1'b1; branch_target = 32'd3;
    step(); check_all("restart3", 32'd3, 32'h0, 32'd4, 1'b0, 1'b0);
    flush = 1'b0;
    step(); check_all("r3", 32'd4, 32'hC000_0003, 32'd4, 1'b1, 1'b0);
    step(); check_all("r4", 32'd5, 32'hC000_0004, 32'd5, 1'b1, 1'b0);
    rst = 1'b1; flush = 1'b1; branch_target = 32'd50;
    step(); check_all("midrst", 32'd0, 32'h0, 32'd0, 1'b0, 1'b0);
    rst = 1'b0; flush = 1'b0;
    step(); check_all("idle2", 32'd0, 32'h0, 32'd0, 1'b0, 1'b0);
    step(); check_all("w0_again", 32'd1, 32'h0023_00AA, 32'd1, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
